// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_if
//  Description : Byte-stream input and instruction-RAM write port of the
//                instruction memory loader, grouped as one bundle.
//                master : loader side. It consumes the byte stream and drives
//                         the RAM write port.
//                slave  : environment side. It sources the byte stream and
//                         observes the RAM write port.
//  Signals     : byte_in[7:0], byte_valid, byte_ready,
//                we, waddr[31:0] (byte address), wdata[31:0]
//  Revision    : 1.0 - initial release
// ============================================================================
interface imem_loader_if;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;

    modport master (
        input  byte_in,
        input  byte_valid,
        output byte_ready,
        output we,
        output waddr,
        output wdata
    );

    modport slave (
        output byte_in,
        output byte_valid,
        input  byte_ready,
        input  we,
        input  waddr,
        input  wdata
    );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Writer side of the instruction memory. It packs a program
//                byte stream little-endian into 32-bit words and writes each
//                word to word-aligned byte addresses of the instruction RAM.
//                The core is held in reset until a complete image is loaded.
//  Ports       : clk, rst_n      clock, asynchronous active-low reset
//                start, len      begin a load of len words (legal 1..DEPTH)
//                abort           cancel the load in progress
//                bus (master)    byte stream in, RAM write port out
//                cpu_hold        holds the core in reset while high
//                done            load completed successfully
//                error           last start carried an illegal len
//                checksum        sum mod 256 of bytes accepted since start
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              start,
    input  wire logic [ADDR_W:0]   len,
    input  wire logic              abort,
    imem_loader_if.master          bus,
    output logic                   cpu_hold,
    output logic                   done,
    output logic                   error,
    output logic [7:0]             checksum
);

    localparam logic [ADDR_W:0]   c_DEPTH    = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_LEN_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] c_IDX_ONE  = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_word_idx;
    logic [1:0]        r_byte_cnt;
    logic [ADDR_W:0]   r_len;

    logic w_len_ok;
    logic w_xfer;
    logic w_last_word;

    assign w_len_ok    = (len != '0) && (len <= c_DEPTH);
    // byte_ready is itself a registered decode of S_LOAD, so the handshake
    // can only complete while loading.
    assign w_xfer      = bus.byte_valid && bus.byte_ready;
    assign w_last_word = ({1'b0, r_word_idx} == (r_len - c_LEN_ONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_word_idx     <= '0;
            r_byte_cnt     <= '0;
            r_len          <= '0;
            bus.byte_ready <= 1'b0;
            bus.we         <= 1'b0;
            bus.waddr      <= '0;
            bus.wdata      <= '0;
            cpu_hold       <= 1'b1;
            done           <= 1'b0;
            error          <= 1'b0;
            checksum       <= '0;
        end else begin
            // The write enable is a single-cycle pulse raised only on entry
            // to S_WRITE.
            bus.we <= 1'b0;

            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        done <= 1'b0;
                        if (w_len_ok) begin
                            r_state        <= S_LOAD;
                            r_len          <= len;
                            r_word_idx     <= '0;
                            r_byte_cnt     <= '0;
                            checksum       <= '0;
                            error          <= 1'b0;
                            cpu_hold       <= 1'b1;
                            bus.byte_ready <= 1'b1;
                        end else begin
                            // cpu_hold is left alone: a bad request must not
                            // disturb a core that is already running.
                            r_state        <= S_ERR;
                            error          <= 1'b1;
                            bus.byte_ready <= 1'b0;
                        end
                    end
                end

                S_LOAD: begin
                    if (abort) begin
                        // Abort wins over a simultaneous handshake; the
                        // partial word is simply dropped.
                        r_state        <= S_IDLE;
                        bus.byte_ready <= 1'b0;
                    end else if (w_xfer) begin
                        bus.wdata[8*r_byte_cnt +: 8] <= bus.byte_in;
                        checksum   <= checksum + bus.byte_in;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_state        <= S_WRITE;
                            bus.byte_ready <= 1'b0;
                            bus.we         <= 1'b1;
                            bus.waddr      <= {{(30-ADDR_W){1'b0}}, r_word_idx, 2'b00};
                        end
                    end
                end

                S_WRITE: begin
                    if (abort) begin
                        r_state        <= S_IDLE;
                        bus.byte_ready <= 1'b0;
                    end else if (w_last_word) begin
                        r_state  <= S_DONE;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else begin
                        r_state        <= S_LOAD;
                        r_word_idx     <= r_word_idx + c_IDX_ONE;
                        r_byte_cnt     <= '0;
                        bus.byte_ready <= 1'b1;
                    end
                end

                default: begin
                    r_state        <= S_IDLE;
                    bus.byte_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Self-checking bench for imem_loader. Expected RAM writes are
//                queued when the bytes of a word are driven and compared as
//                the write pulses appear on the RAM port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [6:0] len   = '0;
    logic       cpu_hold;
    logic       done;
    logic       error;
    logic [7:0] checksum;

    int checks   = 0;
    int failures = 0;
    int writes   = 0;

    logic [63:0] exp_q[$];
    logic [63:0] mon_exp;
    logic [7:0]  sum_model = '0;
    logic [31:0] img[64];

    imem_loader_if bus ();

    imem_loader #(.DEPTH(64), .ADDR_W(6)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .len      (len),
        .abort    (abort),
        .bus      (bus.master),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error),
        .checksum (checksum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every write pulse must match the oldest queued word.
    always @(negedge clk) begin
        if (bus.we === 1'b1) begin
            writes++;
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_write observed=%h/%h expected=no write",
                       bus.waddr, bus.wdata);
            end
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                chk("write_addr", bus.waddr, mon_exp[63:32]);
                chk("write_data", bus.wdata, mon_exp[31:0]);
            end
            chk("ready_in_write", {31'b0, bus.byte_ready}, 32'd0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n = 0;
        if (gap) begin
            bus.byte_valid = 1'b0;
            @(posedge clk); #1;
        end
        bus.byte_valid = 1'b1;
        bus.byte_in    = b;
        @(negedge clk);
        while (bus.byte_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $error("FAIL handshake_timeout observed=no ready expected=ready");
        end
        sum_model = sum_model + b;
        @(posedge clk); #1;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap, input bit push, input int idx);
        if (push) exp_q.push_back({32'(idx * 4), w});
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
    endtask

    task automatic do_start(input int l);
        start     = 1'b1;
        len       = 7'(l);
        sum_model = '0;
        @(posedge clk); #1;
        start = 1'b0;
        len   = 7'h55;      // later len changes must be ignored
    endtask

    task automatic finish_load(input string tag);
        bus.byte_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_done"},     {31'b0, done},     32'd1);
        chk({tag, "_cpu_hold"}, {31'b0, cpu_hold}, 32'd0);
        chk({tag, "_error"},    {31'b0, error},    32'd0);
        chk({tag, "_checksum"}, {24'b0, checksum}, {24'b0, sum_model});
        chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic load(input int n, input bit gap, input string tag);
        do_start(n);
        for (int i = 0; i < n; i++) send_word(img[i], gap, 1'b1, i);
        finish_load(tag);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"},    {31'b0, bus.byte_ready}, 32'd0);
        chk({tag, "_we"},       {31'b0, bus.we},         32'd0);
        chk({tag, "_waddr"},    bus.waddr,               32'd0);
        chk({tag, "_wdata"},    bus.wdata,               32'd0);
        chk({tag, "_done"},     {31'b0, done},           32'd0);
        chk({tag, "_error"},    {31'b0, error},          32'd0);
        chk({tag, "_checksum"}, {24'b0, checksum},       32'd0);
        chk({tag, "_cpu_hold"}, {31'b0, cpu_hold},       32'd1);
    endtask

    initial begin
        logic hold_before;
        int   w0;

        bus.byte_valid = 1'b0;
        bus.byte_in    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: two-word image, back-to-back bytes
        img[0] = 32'h00A00513;
        img[1] = 32'h00100593;
        load(2, 1'b0, "t1");
        chk("t1_checksum_const", {24'b0, checksum}, 32'h60);

        // 2: same image, valid toggling
        load(2, 1'b1, "t2");

        // 3: illegal lengths, then a legal one
        hold_before = cpu_hold;
        do_start(0);
        chk("t3_len0_error",    {31'b0, error},    32'd1);
        chk("t3_len0_cpu_hold", {31'b0, cpu_hold}, {31'b0, hold_before});
        chk("t3_len0_done",     {31'b0, done},     32'd0);
        bus.byte_valid = 1'b1;
        bus.byte_in    = 8'hAA;
        repeat (3) @(posedge clk);
        #1;
        chk("t3_err_ready", {31'b0, bus.byte_ready}, 32'd0);
        bus.byte_valid = 1'b0;
        do_start(65);
        chk("t3_len65_error", {31'b0, error},          32'd1);
        chk("t3_len65_ready", {31'b0, bus.byte_ready}, 32'd0);
        img[0] = 32'hDEADBEEF;
        load(1, 1'b0, "t3_ok");

        // 4: full depth
        for (int i = 0; i < 64; i++) img[i] = 32'(i);
        w0 = writes;
        load(64, 1'b0, "t4");
        chk("t4_write_count", 32'(writes - w0), 32'd64);
        chk("t4_last_waddr",  bus.waddr,        32'h0000_00FC);

        // 5: abort after six bytes of a three-word load
        img[0] = 32'h11223344;
        img[1] = 32'h55667788;
        w0 = writes;
        do_start(3);
        send_word(img[0], 1'b0, 1'b1, 0);
        send_byte(img[1][7:0], 1'b0);
        send_byte(img[1][15:8], 1'b0);
        abort          = 1'b1;   // handshake offered in the same cycle
        bus.byte_valid = 1'b1;
        bus.byte_in    = img[1][23:16];
        @(posedge clk); #1;
        abort          = 1'b0;
        bus.byte_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("t5_write_count", 32'(writes - w0),      32'd1);
        chk("t5_ready",       {31'b0, bus.byte_ready}, 32'd0);
        chk("t5_cpu_hold",    {31'b0, cpu_hold},     32'd1);
        chk("t5_done",        {31'b0, done},         32'd0);
        img[0] = 32'hCAFEF00D;
        load(1, 1'b0, "t5_reload");

        // 6a: reset asserted during the write cycle
        do_start(1);
        send_word(32'h0BADF00D, 1'b0, 1'b0, 0);
        chk("t6_we_latency", {31'b0, bus.we}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("t6_rst");
        bus.byte_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 6b: start during LOAD is ignored
        img[0] = 32'h01020304;
        img[1] = 32'hA5A55A5A;
        do_start(2);
        send_word(img[0], 1'b0, 1'b1, 0);
        bus.byte_valid = 1'b0;
        start = 1'b1;
        len   = 7'd1;
        @(posedge clk); #1;
        start = 1'b0;
        send_word(img[1], 1'b0, 1'b1, 1);
        finish_load("t6_start_ignored");

        repeat (3) @(posedge clk);
        #1;
        chk("final_sb_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
